i_fetch: RTL and testbench
==========================

// Module: i_fetch
// PURPOSE
//  Instruction-fetch initiator for the RAPID core: owns the PC, issues read requests to i_cache
//  over its address/operation/data/done interface, and presents fetched instructions to decode.
//  Sits between i_cache and the decode stage; sole master of the i_cache request port.
//  Handles redirects (branch/jump/trap) and watchdogs the cache with a timeout counter.
// PARAMETERS
//  XLEN          32            data/address width
//  RESET_PC      32'h0000_0000 PC loaded on reset; bits [1:0] must be 0
//  TIMEOUT       256           max cycles waiting for i_cache_done; 0 disables watchdog
// PORTS
//  i_clk             in   1        clock, all logic on rising edge
//  i_rst             in   1        synchronous, active-high reset
//  o_cache_address   out  XLEN     fetch address to i_cache (word aligned)
//  o_cache_operation out  cache_operation  CACHE_READ while a request is open, else CACHE_NOP
//  i_cache_data      in   XLEN     instruction word from i_cache (signed there; treated as raw bits)
//  i_cache_done      in   1        one-cycle pulse: i_cache_data valid this cycle
//  i_redirect        in   1        one-cycle pulse: change flow to i_redirect_pc
//  i_redirect_pc     in   XLEN     redirect target; bits [1:0] forced to 0 on capture
//  i_ready           in   1        decode accepts o_instr this cycle when o_valid=1
//  o_valid           out  1        o_instr/o_pc hold a valid fetched instruction
//  o_instr           out  XLEN     fetched instruction
//  o_pc              out  XLEN     address of o_instr
//  o_fault           out  1        sticky: cache timeout occurred; cleared only by reset
// BEHAVIOUR
//  Reset: state IDLE, pc<=RESET_PC, o_valid=0, o_instr=0, o_pc=0, o_fault=0, drop=0, timer=0,
//   o_cache_operation=CACHE_NOP, o_cache_address=0. Reset mid-request abandons it; a late done is ignored in IDLE.
//  FSM (all outputs registered):
//   IDLE : next cycle -> REQ, drive address=pc, op=CACHE_READ. Unless o_fault=1 (stay IDLE).
//   REQ  : hold address and CACHE_READ stable until i_cache_done. On done:
//          drop=0 -> latch o_instr=i_cache_data, o_pc=pc, o_valid=1, op=CACHE_NOP -> VALID.
//          drop=1 -> discard data, drop<=0, pc already = redirect target -> GAP.
//   GAP  : one cycle CACHE_NOP, then -> REQ at pc (cache sees op drop between requests).
//   VALID: op=CACHE_NOP. If i_ready: o_valid<=0, pc<=pc+4 -> REQ with new address next cycle.
//  Request protocol: op is CACHE_NOP for >=1 cycle between consecutive requests; address never
//   changes while op=CACHE_READ. Best throughput: 1 instr per (cache latency + 2) cycles.
//  Redirect (captured any state, priority over i_ready in same cycle):
//   IDLE/GAP: pc<=target. VALID: o_valid<=0, pc<=target -> REQ. REQ: pc<=target, drop<=1; the open
//   request still completes (cache cannot abort). Redirect on the same cycle as done in REQ: data
//   discarded, -> GAP. Second redirect while drop=1 overwrites pc only.
//  PC arithmetic: pc+4 mod 2^XLEN (32'hFFFF_FFFC -> 0), no fault on wrap.
//  Watchdog: timer counts cycles in REQ, cleared on entering REQ; if TIMEOUT!=0 and timer reaches
//   TIMEOUT-1 without done -> o_fault<=1, op=CACHE_NOP, o_valid=0, -> IDLE and stay there.
//  i_cache_done outside REQ is ignored. i_ready while o_valid=0 is ignored.
// STRUCTURE
//  rapid_pkg: cache_operation enum (CACHE_NOP, CACHE_READ used here), fetch_state_t
//   {IDLE, REQ, GAP, VALID}, constant INSTR_BYTES=4.
//  Single module, no sub-module; FSM, pc register, output register and watchdog counter inline.
//  Counter width $clog2(TIMEOUT+1).
// TESTING
//  1 Reset, cache model done 2 cycles after READ, i_ready=1 -> o_pc 0,4,8 with matching o_instr;
//    op returns to CACHE_NOP one cycle between requests; address stable while READ.
//  2 i_ready=0 for 5 cycles with o_valid=1 -> o_instr/o_pc held, no new READ issued;
//    i_ready=1 -> next request at o_pc+4.
//  3 i_redirect to 32'h0000_1002 during open REQ -> old data discarded (o_valid stays 0),
//    next READ at 32'h0000_1000, o_pc=32'h1000 delivered.
//  4 Redirect and i_cache_done same cycle; and redirect+i_ready same cycle in VALID -> redirect
//    wins both, next READ at target, no instruction from old path delivered.
//  5 PC at 32'hFFFF_FFFC accepted -> next READ at 32'h0000_0000.
//  6 TIMEOUT=8, cache never responds -> o_fault=1 at 8th REQ cycle, op=CACHE_NOP, stays IDLE;
//    i_rst for 1 cycle -> o_fault=0, fetch resumes at RESET_PC.

Source files
------------

// File: rtl/rapid_pkg.sv
// rtl/rapid_pkg.sv - shared types and constants for the RAPID instruction-fetch path
package rapid_pkg;

    typedef enum logic [1:0] {
        CACHE_NOP   = 2'd0,
        CACHE_READ  = 2'd1,
        CACHE_WRITE = 2'd2
    } cache_operation;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        GAP   = 2'd2,
        VALID = 2'd3
    } fetch_state_t;

    localparam int INSTR_BYTES = 4;

endpackage

// File: rtl/i_fetch.sv
// rtl/i_fetch.sv - PC owner and i_cache read initiator feeding decode, with redirect and watchdog
module i_fetch
    import rapid_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter int              TIMEOUT  = 256
) (
    input  logic            i_clk,
    input  logic            i_rst,
    output logic [XLEN-1:0] o_cache_address,
    output cache_operation  o_cache_operation,
    input  logic [XLEN-1:0] i_cache_data,
    input  logic            i_cache_done,
    input  logic            i_redirect,
    input  logic [XLEN-1:0] i_redirect_pc,
    input  logic            i_ready,
    output logic            o_valid,
    output logic [XLEN-1:0] o_instr,
    output logic [XLEN-1:0] o_pc,
    output logic            o_fault
);

    localparam int              TW      = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [TW-1:0]   T_LAST  = TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam logic [XLEN-1:0] PC_STEP = XLEN'(INSTR_BYTES);
    localparam logic [XLEN-1:0] ALIGN   = ~XLEN'(3);

    fetch_state_t   state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] addr_q, addr_d;
    cache_operation op_q, op_d;
    logic           valid_q, valid_d;
    logic [XLEN-1:0] instr_q, instr_d;
    logic [XLEN-1:0] opc_q, opc_d;
    logic           fault_q, fault_d;
    logic           drop_q, drop_d;
    logic [TW-1:0]  timer_q, timer_d;

    logic [XLEN-1:0] target;
    logic [XLEN-1:0] pc_eff;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        addr_d  = addr_q;
        op_d    = op_q;
        valid_d = valid_q;
        instr_d = instr_q;
        opc_d   = opc_q;
        fault_d = fault_q;
        drop_d  = drop_q;
        timer_d = timer_q;

        target = i_redirect_pc & ALIGN;
        pc_eff = i_redirect ? target : pc_q;

        // A redirect always retargets the PC; per-state handling below decides what else it does.
        if (i_redirect) begin
            pc_d = target;
        end

        case (state_q)
            IDLE: begin
                if (!fault_q) begin
                    state_d = REQ;
                    op_d    = CACHE_READ;
                    addr_d  = pc_eff;
                    timer_d = '0;
                end
            end

            GAP: begin
                state_d = REQ;
                op_d    = CACHE_READ;
                addr_d  = pc_eff;
                timer_d = '0;
            end

            REQ: begin
                if (i_cache_done) begin
                    op_d = CACHE_NOP;
                    if (drop_q || i_redirect) begin
                        drop_d  = 1'b0;
                        state_d = GAP;
                    end else begin
                        valid_d = 1'b1;
                        instr_d = i_cache_data;
                        opc_d   = pc_q;
                        state_d = VALID;
                    end
                end else if ((TIMEOUT != 0) && (timer_q == T_LAST)) begin
                    fault_d = 1'b1;
                    op_d    = CACHE_NOP;
                    valid_d = 1'b0;
                    drop_d  = 1'b0;
                    state_d = IDLE;
                end else begin
                    timer_d = timer_q + TW'(1);
                    // The cache cannot abort, so the in-flight word is marked for discard.
                    if (i_redirect) begin
                        drop_d = 1'b1;
                    end
                end
            end

            VALID: begin
                if (i_redirect) begin
                    valid_d = 1'b0;
                    state_d = REQ;
                    op_d    = CACHE_READ;
                    addr_d  = target;
                    timer_d = '0;
                end else if (i_ready) begin
                    valid_d = 1'b0;
                    pc_d    = pc_q + PC_STEP;
                    state_d = REQ;
                    op_d    = CACHE_READ;
                    addr_d  = pc_q + PC_STEP;
                    timer_d = '0;
                end
            end

            default: begin
                state_d = IDLE;
                op_d    = CACHE_NOP;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= IDLE;
            pc_q    <= RESET_PC;
            addr_q  <= '0;
            op_q    <= CACHE_NOP;
            valid_q <= 1'b0;
            instr_q <= '0;
            opc_q   <= '0;
            fault_q <= 1'b0;
            drop_q  <= 1'b0;
            timer_q <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            addr_q  <= addr_d;
            op_q    <= op_d;
            valid_q <= valid_d;
            instr_q <= instr_d;
            opc_q   <= opc_d;
            fault_q <= fault_d;
            drop_q  <= drop_d;
            timer_q <= timer_d;
        end
    end

    assign o_cache_address   = addr_q;
    assign o_cache_operation = op_q;
    assign o_valid           = valid_q;
    assign o_instr           = instr_q;
    assign o_pc              = opc_q;
    assign o_fault           = fault_q;

endmodule

// File: tb/tb_i_fetch.sv
// tb/tb_i_fetch.sv - directed self-checking bench for i_fetch
module tb_i_fetch;
    import rapid_pkg::*;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [31:0]    cache_address;
    cache_operation cache_op;
    logic [31:0]    cache_data = '0;
    logic           cache_done = 1'b0;
    logic           redirect = 1'b0;
    logic [31:0]    redirect_pc = '0;
    logic           ready = 1'b0;
    logic           valid;
    logic [31:0]    instr;
    logic [31:0]    pc;
    logic           fault;

    int checks = 0;
    int errors = 0;

    i_fetch #(
        .XLEN    (32),
        .RESET_PC(32'h0000_0000),
        .TIMEOUT (8)
    ) dut (
        .i_clk            (clk),
        .i_rst            (rst),
        .o_cache_address  (cache_address),
        .o_cache_operation(cache_op),
        .i_cache_data     (cache_data),
        .i_cache_done     (cache_done),
        .i_redirect       (redirect),
        .i_redirect_pc    (redirect_pc),
        .i_ready          (ready),
        .o_valid          (valid),
        .o_instr          (instr),
        .o_pc             (pc),
        .o_fault          (fault)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem(input logic [31:0] a);
        return a ^ 32'hC3A5_0F00;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_op(input string tag, input cache_operation exp);
        check(tag, 32'(cache_op), 32'(exp));
    endtask

    // Expects a READ already open at a; answers it two cycles after it appeared.
    task automatic fetch_one(input logic [31:0] a, input string tag);
        check_op({tag, "_op_read"}, CACHE_READ);
        check({tag, "_addr"}, cache_address, a);
        tick();
        check_op({tag, "_op_hold"}, CACHE_READ);
        check({tag, "_addr_hold"}, cache_address, a);
        cache_done = 1'b1;
        cache_data = mem(a);
        tick();
        cache_done = 1'b0;
        cache_data = '0;
        check({tag, "_valid"}, 32'(valid), 32'd1);
        check({tag, "_pc"}, pc, a);
        check({tag, "_instr"}, instr, mem(a));
        check_op({tag, "_op_nop"}, CACHE_NOP);
    endtask

    initial begin
        // reset state
        tick();
        tick();
        check("rst_valid", 32'(valid), 32'd0);
        check("rst_instr", instr, 32'd0);
        check("rst_pc", pc, 32'd0);
        check("rst_fault", 32'(fault), 32'd0);
        check("rst_addr", cache_address, 32'd0);
        check_op("rst_op", CACHE_NOP);
        rst = 1'b0;
        tick();

        // streaming fetch 0,4,8 with decode always ready
        ready = 1'b1;
        fetch_one(32'h0, "f0");
        tick();
        check("f1_valid_drop", 32'(valid), 32'd0);
        fetch_one(32'h4, "f1");
        tick();
        fetch_one(32'h8, "f2");
        ready = 1'b0;

        // decode stall holds output, no new request
        for (int i = 0; i < 5; i++) begin
            tick();
            check_op("stall_op", CACHE_NOP);
            check("stall_valid", 32'(valid), 32'd1);
        end
        check("stall_pc", pc, 32'h8);
        check("stall_instr", instr, mem(32'h8));
        ready = 1'b1;
        tick();
        ready = 1'b0;
        check_op("resume_op", CACHE_READ);
        check("resume_addr", cache_address, 32'hC);
        check("resume_valid", 32'(valid), 32'd0);

        // redirect during open request: old word discarded, refetch at aligned target
        redirect = 1'b1;
        redirect_pc = 32'h0000_1002;
        tick();
        redirect = 1'b0;
        check_op("rd_req_op", CACHE_READ);
        check("rd_req_addr", cache_address, 32'hC);
        cache_done = 1'b1;
        cache_data = mem(32'hC);
        tick();
        cache_done = 1'b0;
        check("rd_drop_valid", 32'(valid), 32'd0);
        check_op("rd_gap_op", CACHE_NOP);
        tick();
        fetch_one(32'h0000_1000, "rd");

        // redirect beats i_ready in VALID
        ready = 1'b1;
        redirect = 1'b1;
        redirect_pc = 32'h0000_2000;
        tick();
        ready = 1'b0;
        redirect = 1'b0;
        check("rv_valid", 32'(valid), 32'd0);
        check_op("rv_op", CACHE_READ);
        check("rv_addr", cache_address, 32'h0000_2000);
        tick();

        // redirect on the same cycle as done: data discarded
        cache_done = 1'b1;
        cache_data = mem(32'h2000);
        redirect = 1'b1;
        redirect_pc = 32'h0000_3000;
        tick();
        cache_done = 1'b0;
        redirect = 1'b0;
        check("rdone_valid", 32'(valid), 32'd0);
        check_op("rdone_gap_op", CACHE_NOP);
        tick();
        fetch_one(32'h0000_3000, "rdone");

        // PC wrap from the top of the address space
        redirect = 1'b1;
        redirect_pc = 32'hFFFF_FFFC;
        tick();
        redirect = 1'b0;
        fetch_one(32'hFFFF_FFFC, "wrap");
        ready = 1'b1;
        tick();
        ready = 1'b0;
        check_op("wrap_next_op", CACHE_READ);
        check("wrap_next_addr", cache_address, 32'h0);

        // watchdog: cache never answers, fault after 8 REQ cycles
        for (int i = 0; i < 7; i++) begin
            tick();
        end
        check_op("wd_op_before", CACHE_READ);
        check("wd_fault_before", 32'(fault), 32'd0);
        tick();
        check("wd_fault", 32'(fault), 32'd1);
        check_op("wd_op_nop", CACHE_NOP);
        check("wd_valid", 32'(valid), 32'd0);
        tick();
        tick();
        tick();
        check("wd_fault_sticky", 32'(fault), 32'd1);
        check_op("wd_stay_idle", CACHE_NOP);

        // reset clears fault and fetch restarts at RESET_PC
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rr_fault", 32'(fault), 32'd0);
        check_op("rr_op", CACHE_NOP);
        tick();
        fetch_one(32'h0, "rr");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
